// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared definitions for the shift/rotate execute unit: the op
//            encoding, default datapath/amount widths, and a bit-reverse
//            helper used to map left operations onto a right-only core.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int AW_DEFAULT = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // Mirror a DW-wide vector: bit i moves to bit DW-1-i.
  function automatic logic [DW_DEFAULT-1:0] bit_rev(input logic [DW_DEFAULT-1:0] v);
    logic [DW_DEFAULT-1:0] r;
    r = '0;
    for (int i = 0; i < DW_DEFAULT; i++) begin
      r[i] = v[DW_DEFAULT-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/right_shift_rotator.sv
`default_nettype none
// ============================================================================
// Module   : right_shift_rotator
// Purpose  : 16-bit combinational right shift / rotate core (log barrel).
// Ports    : data   - operand
//            shift  - 1 = logical shift right (zero fill), 0 = rotate right
//            amt    - amount 0..15
//            result - shifted/rotated operand
// Revision : 1.0 - initial release
// ============================================================================
module right_shift_rotator
  import shift_pkg::*;
(
  input  logic [DW_DEFAULT-1:0] data,
  input  logic                  shift,
  input  logic [AW_DEFAULT-1:0] amt,
  output logic [DW_DEFAULT-1:0] result
);

  // Stage k moves the word right by 2**k when amt[k] is set. The bits that
  // fall off the bottom re-enter at the top for rotates, zeros for shifts.
  logic [AW_DEFAULT:0][DW_DEFAULT-1:0] w_stage;

  assign w_stage[0] = data;

  for (genvar k = 0; k < AW_DEFAULT; k++) begin : g_stage
    localparam int C_N = 1 << k;
    logic [C_N-1:0] w_fill;

    assign w_fill         = shift ? '0 : w_stage[k][C_N-1:0];
    assign w_stage[k+1]   = amt[k] ? {w_fill, w_stage[k][DW_DEFAULT-1:C_N]} : w_stage[k];
  end

  assign result = w_stage[AW_DEFAULT];

endmodule
`default_nettype wire

// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_issue_stage
// Purpose  : Two-stage pipelined shift/rotate execute unit. Requests enter
//            over a valid/ready handshake, pass S1 -> core -> S2, and leave
//            over a second valid/ready handshake in acceptance order. Left
//            ops bit-reverse the operand before the right-only core and the
//            core result before S2.
// Ports    : clk, rst_n (async, active-low), flush (sync kill of in-flight)
//            in_valid/in_ready/in_op/in_data/in_amt  - request side
//            out_valid/out_ready/out_data            - result side
//            out_zero - registered result==0 flag (SHIFT_ZERO_FLAG_EN only)
// Config   : `define SHIFT_ZERO_FLAG_EN to add the out_zero port and flag.
// Revision : 1.0 - initial release
// ============================================================================
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef SHIFT_ZERO_FLAG_EN
  ,
  output logic          out_zero
`endif
);

  // The core and the reversal helper are fixed at 16 bits.
  if (DW != 16 || AW != 4) begin : g_bad_width
    $error("shift_issue_stage: only DW=16, AW=4 is supported");
  end

  // --------------------------------------------------------------------------
  // Handshake / pipeline control
  // --------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_fire;
  logic w_s1_move;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv && !flush;
  assign w_in_fire = in_valid && in_ready;
  // S1 content is handed to S2 on this edge.
  assign w_s1_move = r_s1_valid && w_s2_adv && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_in_fire;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S1: op decode and operand pre-reversal for left ops
  // --------------------------------------------------------------------------
  logic            w_in_left;
  logic            w_in_shift;
  logic [DW-1:0]   w_in_mapped;
  logic            r_s1_left;
  logic            r_s1_shift;
  logic [AW-1:0]   r_s1_amt;
  logic [DW-1:0]   r_s1_data;

  assign w_in_left   = (in_op == OP_ROL) || (in_op == OP_SLL);
  assign w_in_shift  = (in_op == OP_SLL) || (in_op == OP_SRL);
  assign w_in_mapped = w_in_left ? bit_rev(in_data) : in_data;

  // Data path registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_left  <= w_in_left;
      r_s1_shift <= w_in_shift;
      r_s1_amt   <= in_amt;
      r_s1_data  <= w_in_mapped;
    end
  end

  // --------------------------------------------------------------------------
  // Core between the stages, then post-reversal for left ops
  // --------------------------------------------------------------------------
  logic [DW-1:0] w_core_res;
  logic [DW-1:0] w_s2_next;

  right_shift_rotator u_core (
    .data   (r_s1_data),
    .shift  (r_s1_shift),
    .amt    (r_s1_amt),
    .result (w_core_res)
  );

  assign w_s2_next = r_s1_left ? bit_rev(w_core_res) : w_core_res;

  // --------------------------------------------------------------------------
  // S2: result register. Only loads when S1 hands over, so a stalled result
  // stays put while out_valid && !out_ready.
  // --------------------------------------------------------------------------
  logic [DW-1:0] r_s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_data <= '0;
    end else if (w_s1_move) begin
      r_s2_data <= w_s2_next;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

`ifdef SHIFT_ZERO_FLAG_EN
  logic r_s2_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_zero <= 1'b0;
    end else if (w_s1_move) begin
      r_s2_zero <= (w_s2_next == '0);
    end
  end

  assign out_zero = r_s2_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_issue_stage
// Purpose  : Self-checking bench for shift_issue_stage: directed vector
//            table, streaming, backpressure, flush, mid-stream reset and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef SHIFT_ZERO_FLAG_EN
  logic        out_zero;
`endif

  shift_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: arithmetic definition of the four ops, and a queue of
  // in-flight results tagged with the edge count at which they were accepted.
  // --------------------------------------------------------------------------
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] x,
                                            input logic [3:0] n);
    int unsigned v, s, r;
    v = x;
    s = n;
    case (op)
      2'b00:   r = (v << s) | (v >> (16 - s));
      2'b01:   r = v << s;
      2'b10:   r = (v >> s) | (v << (16 - s));
      default: r = v >> s;
    endcase
    return r[15:0];
  endfunction

  typedef struct {
    logic [15:0] d;
    int          acc;
  } ent_t;

  ent_t        q[$];
  int          cyc;
  int          total;
  int          bad;
  int          accepted;
  logic [15:0] cur_exp;
  logic        hold_pend;
  logic [15:0] hold_d;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: inputs are already driven; check outputs, then let the edge
  // happen and update the model. Entered and left at a falling edge.
  task automatic tick();
    logic in_fire, out_fire, exp_rdy, exp_ov;
    #1;
    if (hold_pend) begin
      chk("hold_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_data", out_data, hold_d);
    end
    exp_rdy = !flush && (q.size() < 2 || out_ready);
    chk("in_ready", {15'd0, in_ready}, {15'd0, exp_rdy});
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 1);
    chk("out_valid", {15'd0, out_valid}, {15'd0, exp_ov});
    if (out_valid && exp_ov) chk("out_data", out_data, q[0].d);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready && exp_ov;
    hold_pend = out_valid && !out_ready && !flush;
    hold_d    = out_data;
    @(posedge clk);
    cyc++;
    if (flush) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        q.push_back('{d: cur_exp, acc: cyc});
        accepted++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    cur_exp  = ref_shift(op, d, a);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("drain_empty", 16'(q.size()), 16'd0);
    tick();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] d;
    logic [3:0]  a;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    total = 0; bad = 0; cyc = 0; accepted = 0; hold_pend = 1'b0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_data = 16'h0; in_amt = 4'h0; cur_exp = 16'h0;

    vt[0] = '{2'b01, 16'h0001, 4'd4,  16'h0010};
    vt[1] = '{2'b00, 16'h8001, 4'd1,  16'h0003};
    vt[2] = '{2'b10, 16'h0001, 4'd15, 16'h0002};
    vt[3] = '{2'b11, 16'h8000, 4'd15, 16'h0001};
    vt[4] = '{2'b00, 16'hA5C3, 4'd0,  16'hA5C3};
    vt[5] = '{2'b01, 16'hA5C3, 4'd0,  16'hA5C3};
    vt[6] = '{2'b10, 16'hA5C3, 4'd0,  16'hA5C3};
    vt[7] = '{2'b11, 16'hA5C3, 4'd0,  16'hA5C3};
    vt[8] = '{2'b00, 16'h1234, 4'd8,  16'h3412};
    vt[9] = '{2'b11, 16'hFFFF, 4'd12, 16'h000F};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);

    // Directed table: one request each, consumer always ready
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].op, vt[i].d, vt[i].a);
      cur_exp = vt[i].exp;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
    end

    // Streaming: 8 back-to-back, no in_ready drop, one result per cycle
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
      tick();
    end
    chk("stream_accepted", 16'(accepted), 16'd8);
    drain();

    // Backpressure: 4 cycles of out_ready=0 with in_valid held
    accepted  = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
      tick();
    end
    chk("bp_accepted", 16'(accepted), 16'd2);
    drain();

    // Flush with FULL pipeline plus an offered request
    out_ready = 1'b0;
    drive(2'b01, 16'h00FF, 4'd3); tick();
    drive(2'b10, 16'h0F0F, 4'd5); tick();
    drive(2'b00, 16'hBEEF, 4'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    out_ready = 1'b1;
    drive(2'b11, 16'h00F0, 4'd4);
    cur_exp = 16'h000F;
    tick();
    drain();

    // Reset pulsed mid-stream
    out_ready = 1'b0;
    drive(2'b01, 16'h1111, 4'd1); tick();
    drive(2'b01, 16'h2222, 4'd2); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("mrst_out_data", out_data, 16'h0000);
    q.delete();
    hold_pend = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
